// File: rtl/gray_seq_gen.sv
// Gray-code sequence generator: binary counter presented as registered Gray code on a valid/ready stream.
// Optional down-counting is compiled in with `define GRAY_SEQ_DOWN_EN; otherwise `dir` is ignored.
module gray_seq_gen #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             stop_pend_q, stop_pend_d;

    logic [WIDTH-1:0] step_cnt;
    logic             at_term;

`ifdef GRAY_SEQ_DOWN_EN
    assign step_cnt = dir ? (cnt_q - ONE) : (cnt_q + ONE);
    assign at_term  = dir ? (cnt_q == '0) : (cnt_q == '1);
`else
    logic dir_unused;
    assign dir_unused = dir;
    assign step_cnt   = cnt_q + ONE;
    assign at_term    = (cnt_q == '1);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        stop_pend_d = stop_pend_q;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (load) begin
                    cnt_d = load_val;
                end
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (out_ready) begin
                    stop_pend_d = 1'b0;
                    // One-shot mode parks on the terminal code instead of stepping past it
                    if (at_term && !WRAP) begin
                        state_d = DONE;
                    end else begin
                        cnt_d  = step_cnt;
                        wrap_d = at_term;
                        if (stop || stop_pend_q) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DONE: begin
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Gray register tracks the next count so it never lags cnt by a cycle
        gray_d = to_gray(cnt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gray_q      <= '0;
            wrap_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gray_q      <= gray_d;
            wrap_q      <= wrap_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign gray      = gray_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Bench for gray_seq_gen: directed scenarios plus a randomized run against an arithmetic stream model.
// Covers both WRAP settings with two instances; down-count checks follow GRAY_SEQ_DOWN_EN.
module tb_gray_seq_gen;

    localparam int W = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic         stop      = 1'b0;
    logic         load      = 1'b0;
    logic         dir       = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] load_val  = '0;

    logic         w_valid, w_wrap, w_done;
    logic [W-1:0] w_gray;
    logic         o_valid, o_wrap, o_done;
    logic [W-1:0] o_gray;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] tbl [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    always #5 clk = ~clk;

    gray_seq_gen #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .dir(dir), .out_ready(out_ready),
        .out_valid(w_valid), .gray(w_gray), .wrap(w_wrap), .done(w_done)
    );

    gray_seq_gen #(.WIDTH(W), .WRAP(1'b0)) u_once (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .dir(dir), .out_ready(out_ready),
        .out_valid(o_valid), .gray(o_gray), .wrap(o_wrap), .done(o_done)
    );

    function automatic logic [31:0] g(input int n);
        return 32'(n ^ (n >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; dir = 1'b0; out_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic expect_run(input string tag, input int n, input bit wr);
        chk({tag, "_valid"}, 32'(w_valid), 32'd1);
        chk({tag, "_gray"}, 32'(w_gray), g(n));
        chk({tag, "_wrap"}, 32'(w_wrap), 32'(wr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] prev;
        int           n;
        bit           wexp;
        bit           r;
        bit           d;

        // Reset state
        cyc();
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_gray", 32'(w_gray), 32'd0);
        chk("rst_wrap", 32'(w_wrap), 32'd0);
        chk("rst_done", 32'(w_done), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        rst_n = 1'b1;

        // Full wrap, up, against the literal code table
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        prev = w_gray;
        for (int i = 0; i < 17; i++) begin
            chk("wrap_valid", 32'(w_valid), 32'd1);
            chk("wrap_code", 32'(w_gray), 32'(tbl[i]));
            chk("wrap_pulse", 32'(w_wrap), 32'(i == 16));
            if (i > 0) chk("wrap_onebit", 32'($countones(w_gray ^ prev)), 32'd1);
            prev = w_gray;
            if (i < 16) cyc();
        end

        // Backpressure on 0110
        repeat (4) cyc();
        chk("bp_pre", 32'(w_gray), 32'b0110);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_valid", 32'(w_valid), 32'd1);
            chk("bp_hold", 32'(w_gray), 32'b0110);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_next", 32'(w_gray), 32'b0111);

        // Load in IDLE, then load/start ignored in RUN
        do_reset();
        load = 1'b1; load_val = 4'd5;
        cyc();
        load = 1'b0;
        chk("ld_valid", 32'(w_valid), 32'd0);
        chk("ld_gray", 32'(w_gray), g(5));
        start = 1'b1;
        cyc();
        start = 1'b0;
        expect_run("ld_run", 5, 1'b0);
        load = 1'b1; load_val = 4'd0; start = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        chk("ld_ignored", 32'(w_gray), g(5));

        // Stop under backpressure on 0011
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("stp_pre", 32'(w_gray), 32'b0011);
        out_ready = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_run("stp_hold1", 2, 1'b0);
        cyc();
        expect_run("stp_hold2", 2, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("stp_valid", 32'(w_valid), 32'd0);
        chk("stp_cnt", 32'(w_gray), g(3));
        cyc();
        chk("stp_idle", 32'(w_valid), 32'd0);
        // Restart resumes from retained count; stop coinciding with a transfer
        start = 1'b1;
        cyc();
        start = 1'b0;
        expect_run("stp_resume", 3, 1'b0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stp_same_valid", 32'(w_valid), 32'd0);
        chk("stp_same_gray", 32'(w_gray), g(4));

        // One-shot termination (WRAP=0), wrap instance observed alongside
        do_reset();
        load = 1'b1; load_val = 4'b1110; start = 1'b1; out_ready = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        chk("os_v0", 32'(o_valid), 32'd1);
        chk("os_c0", 32'(o_gray), 32'b1001);
        chk("os_d0", 32'(o_done), 32'd0);
        cyc();
        chk("os_v1", 32'(o_valid), 32'd1);
        chk("os_c1", 32'(o_gray), 32'b1000);
        chk("os_w_nowrap", 32'(w_wrap), 32'd0);
        cyc();
        chk("os_v2", 32'(o_valid), 32'd0);
        chk("os_done", 32'(o_done), 32'd1);
        chk("os_c2", 32'(o_gray), 32'b1000);
        chk("os_nowrap", 32'(o_wrap), 32'd0);
        chk("os_w_code", 32'(w_gray), 32'b0000);
        chk("os_w_wrap", 32'(w_wrap), 32'd1);
        chk("os_w_done", 32'(w_done), 32'd0);
        cyc();
        chk("os_v3", 32'(o_valid), 32'd0);
        chk("os_d3", 32'(o_done), 32'd0);
        chk("os_c3", 32'(o_gray), 32'b1000);

        // Preload with dir=1
        do_reset();
        load = 1'b1; load_val = 4'b1011; start = 1'b1; dir = 1'b1; out_ready = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
`ifdef GRAY_SEQ_DOWN_EN
        chk("dn_c0", 32'(w_gray), 32'b1110);
        cyc();
        chk("dn_c1", 32'(w_gray), 32'b1111);
        cyc();
        chk("dn_c2", 32'(w_gray), 32'b1101);
        do_reset();
        load = 1'b1; load_val = 4'd1; start = 1'b1; dir = 1'b1; out_ready = 1'b1;
        cyc();
        load = 1'b0; start = 1'b0;
        expect_run("dnw_1", 1, 1'b0);
        cyc();
        expect_run("dnw_0", 0, 1'b0);
        cyc();
        expect_run("dnw_15", 15, 1'b1);
`else
        expect_run("dirign_0", 11, 1'b0);
        cyc();
        expect_run("dirign_1", 12, 1'b0);
        cyc();
        expect_run("dirign_2", 13, 1'b0);
`endif
        dir = 1'b0;

        // Asynchronous reset mid-run
        do_reset();
        start = 1'b1; out_ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        expect_run("ar_pre", 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(w_valid), 32'd0);
        chk("ar_gray", 32'(w_gray), 32'd0);
        chk("ar_wrap", 32'(w_wrap), 32'd0);
        cyc();
        rst_n = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        expect_run("ar_restart", 0, 1'b0);

        // Randomized backpressure and direction against an integer stream model
        do_reset();
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        wexp = 1'b0;
        prev = w_gray;
        for (int i = 0; i < 400; i++) begin
            expect_run("rnd", n, wexp);
            if (w_gray !== prev) chk("rnd_onebit", 32'($countones(w_gray ^ prev)), 32'd1);
            prev = w_gray;
            r = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            out_ready = r;
            dir = d;
            load = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            load_val = W'($urandom);
            cyc();
`ifndef GRAY_SEQ_DOWN_EN
            d = 1'b0;
`endif
            if (r) begin
                wexp = d ? (n == 0) : (n == 15);
                n = d ? (n + 15) % 16 : (n + 1) % 16;
            end else begin
                wexp = 1'b0;
            end
        end
        load = 1'b0; start = 1'b0; dir = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
